apb_rr_master: RTL and testbench

Parametrised multi-requester APB master: NUM_PORTS local requesters issue read/write commands through a valid/ready handshake and a round-robin arbiter. Granted commands are buffered in a DEPTH-entry command FIFO and executed as APB transfers. A tagged response (requester id, read data, error) is returned for every transfer. It is the successor to the fixed two-command APB system, generalised in port count, address/data width and buffering, with back-to-back transfers, slave-error reporting and an optional access timeout.

---
 rtl/apb_rr_master.sv | 234 +++++++++++++++++++++++
 tb/tb_apb_rr_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// Multi-requester APB master: round-robin arbiter, command FIFO and APB
// transfer FSM with tagged responses. Optional access timeout: APB_TIMEOUT_EN.
module apb_rr_master #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 15,
   localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        req_valid_i,
   output logic [NUM_PORTS-1:0]        req_ready_o,
   input  logic [NUM_PORTS-1:0]        req_rnw_i,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i,
   output logic                        psel_o,
   output logic                        penable_o,
   output logic                        pwrite_o,
   output logic [ADDR_W-1:0]           paddr_o,
   output logic [DATA_W-1:0]           pwdata_o,
   input  logic                        pready_i,
   input  logic                        pslverr_i,
   input  logic [DATA_W-1:0]           prdata_i,
   output logic                        rsp_valid_o,
   output logic [ID_W-1:0]             rsp_id_o,
   output logic [DATA_W-1:0]           rsp_rdata_o,
   output logic                        rsp_err_o
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic              rnw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cmd_t                  mem_q [DEPTH];
   cmd_t                  push_cmd, head;
   logic                  fifo_full, fifo_empty, push, pop;
   logic [NUM_PORTS-1:0]  grant;
   logic [ID_W-1:0]       grant_idx;
   logic                  grant_any;
   int                    arb_port;
   logic                  complete, cpl_err, tmo_hit;

   logic [ID_W-1:0]       id_q, id_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]     paddr_q, paddr_d;
   logic [DATA_W-1:0]     pwdata_q, pwdata_d;

   logic                  rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   // Round-robin search starting at ptr_q, the port after the last accepted one.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      arb_port  = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         arb_port = (int'(ptr_q) + k) % NUM_PORTS;
         if (!grant_any && req_valid_i[arb_port]) begin
            grant_any        = 1'b1;
            grant[arb_port]  = 1'b1;
            grant_idx        = ID_W'(arb_port);
         end
      end
   end

   assign req_ready_o = (reset || fifo_full) ? '0 : grant;
   assign push        = grant_any && !fifo_full && !reset;

   always_comb begin
      ptr_d = ptr_q;
      if (push) begin
         ptr_d = (grant_idx == ID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_comb begin
      push_cmd.id    = grant_idx;
      push_cmd.rnw   = req_rnw_i[grant_idx];
      push_cmd.addr  = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
      push_cmd.wdata = req_wdata_i[grant_idx*DATA_W +: DATA_W];
   end

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign head       = mem_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= push_cmd;
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_hit = (state_q == ACCESS) && !pready_i && (tmo_q == TW'(TIMEOUT));

   always_comb begin
      tmo_d = tmo_q;
      if (state_q == SETUP) begin
         tmo_d = '0;
      end else if (state_q == ACCESS && !pready_i && !tmo_hit) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   // No counter: TIMEOUT only feeds a constant-false term here.
   assign tmo_hit = (TIMEOUT < 0);
`endif

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      complete = 1'b0;
      cpl_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (pready_i || tmo_hit) begin
               complete = 1'b1;
               cpl_err  = pready_i ? pslverr_i : 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      id_d     = id_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      if (pop) begin
         id_d     = head.id;
         pwrite_d = !head.rnw;
         paddr_d  = head.addr;
         pwdata_d = head.wdata;
      end
   end

   always_comb begin
      rsp_valid_d = complete;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (complete) begin
         rsp_id_d    = id_q;
         rsp_err_d   = cpl_err;
         rsp_rdata_d = (!pwrite_q && !cpl_err) ? prdata_i : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         id_q        <= '0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         id_q        <= id_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign psel_o      = (state_q != IDLE);
   assign penable_o   = (state_q == ACCESS);
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master (NUM_PORTS=2, DEPTH=4). Inputs change and
// outputs are sampled on the falling edge.
module tb_apb_rr_master;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, req_rnw;
   logic [63:0] req_addr, req_wdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata, rsp_rdata;
   logic        pready, pslverr, rsp_valid, rsp_err;
   logic [0:0]  rsp_id;

   int n_cmp = 0;
   int n_bad = 0;
   int n_acc;
   logic [1:0] rr_ready [12];

   apb_rr_master #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata),
      .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rr_ready = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                   2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      reset = 1'b1; req_valid = '0; req_rnw = '0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;

      // Reset state, with requests pending to show ready is held low
      repeat (2) @(negedge clk);
      req_valid = 2'b11; #1;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);

      // Single read, accepted in cycle t
      @(negedge clk);
      reset = 1'b0; req_valid = 2'b01; req_rnw = 2'b01; req_addr[31:0] = 32'h10;
      pready = 1'b1; prdata = 32'hDEADBEEF; #1;
      chk("rd_ready_t", req_ready, 2'b01);
      @(negedge clk); req_valid = 2'b00;
      chk("rd_psel_t1", psel, 1'b0);
      @(negedge clk);
      chk("rd_psel_t2", psel, 1'b1);
      chk("rd_penable_t2", penable, 1'b0);
      chk("rd_paddr_t2", paddr, 32'h10);
      chk("rd_pwrite_t2", pwrite, 1'b0);
      @(negedge clk);
      chk("rd_penable_t3", penable, 1'b1);
      chk("rd_rsp_valid_t3", rsp_valid, 1'b0);
      @(negedge clk);
      chk("rd_rsp_valid_t4", rsp_valid, 1'b1);
      chk("rd_rsp_id", rsp_id, 1'b0);
      chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("rd_rsp_err", rsp_err, 1'b0);
      @(negedge clk);
      chk("rd_rsp_valid_t5", rsp_valid, 1'b0);
      chk("rd_psel_t5", psel, 1'b0);

      // Round-robin with both ports always valid
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; req_valid = 2'b11; req_rnw = 2'b11;
      req_addr = {32'h200, 32'h100}; prdata = 32'h1234; pready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk("rr_ready", req_ready, rr_ready[i]);
         chk("rr_psel", psel, i >= 2);
         chk("rr_penable", penable, (i >= 2) && (i % 2 == 1));
         chk("rr_rsp_valid", rsp_valid, (i >= 4) && (i % 2 == 0));
         if ((i >= 4) && (i % 2 == 0)) chk("rr_rsp_id", rsp_id, ((i - 4) / 2) % 2);
      end
      req_valid = 2'b00; reset = 1'b1;
      @(negedge clk);

      // Full: DEPTH queued plus one in flight, then backpressure
      reset = 1'b0; req_valid = 2'b01; req_rnw = 2'b00;
      req_addr[31:0] = 32'h40; req_wdata[31:0] = 32'h11; pready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (req_ready[0]) n_acc++;
      end
      chk("full_accepted", n_acc, 5);
      chk("full_ready_low", req_ready, 2'b00);
      pready = 1'b1;
      @(negedge clk); #1;
      chk("full_ready_back", req_ready, 2'b01);
      chk("full_rsp_valid", rsp_valid, 1'b1);
      chk("full_rsp_err", rsp_err, 1'b0);
      chk("full_rsp_rdata", rsp_rdata, 32'h0);
      req_valid = 2'b00;
      repeat (12) @(negedge clk);
      chk("full_drained_psel", psel, 1'b0);

      // Write with three wait states and a slave error
      req_valid = 2'b01; req_rnw = 2'b00; req_addr[31:0] = 32'h80;
      req_wdata[31:0] = 32'hA5; pready = 1'b0; pslverr = 1'b1; prdata = 32'hFFFFFFFF; #1;
      chk("ws_ready", req_ready, 2'b01);
      @(negedge clk); req_valid = 2'b00; req_addr = '0; req_wdata = '0;
      @(negedge clk);
      chk("ws_setup_penable", penable, 1'b0);
      chk("ws_pwrite", pwrite, 1'b1);
      chk("ws_setup_paddr", paddr, 32'h80);
      chk("ws_setup_pwdata", pwdata, 32'hA5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ws_penable", penable, 1'b1);
         chk("ws_paddr", paddr, 32'h80);
         chk("ws_pwdata", pwdata, 32'hA5);
         chk("ws_rsp_valid", rsp_valid, 1'b0);
         if (i == 3) pready = 1'b1;
      end
      @(negedge clk);
      chk("ws_rsp_valid_end", rsp_valid, 1'b1);
      chk("ws_rsp_err", rsp_err, 1'b1);
      chk("ws_rsp_rdata", rsp_rdata, 32'h0);
      chk("ws_rsp_id", rsp_id, 1'b0);
      chk("ws_penable_end", penable, 1'b0);
      pready = 1'b0; pslverr = 1'b0;

`ifdef APB_TIMEOUT_EN
      // Timeout on port 0 read, port 1 read queued behind it
      @(negedge clk);
      req_valid = 2'b01; req_rnw = 2'b11; req_addr = {32'h304, 32'h300}; #1;
      chk("to_ready0", req_ready, 2'b01);
      @(negedge clk); req_valid = 2'b10; #1;
      chk("to_ready1", req_ready, 2'b10);
      @(negedge clk); req_valid = 2'b00;
      chk("to_setup", penable, 1'b0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("to_penable", penable, 1'b1);
         chk("to_rsp_valid", rsp_valid, 1'b0);
      end
      @(negedge clk);
      chk("to_rsp_valid_end", rsp_valid, 1'b1);
      chk("to_rsp_err", rsp_err, 1'b1);
      chk("to_rsp_rdata", rsp_rdata, 32'h0);
      chk("to_rsp_id", rsp_id, 1'b0);
      chk("to_next_setup", penable, 1'b0);
      pready = 1'b1; prdata = 32'h55;
      @(negedge clk);
      chk("to_next_access", penable, 1'b1);
      @(negedge clk);
      chk("to_next_rsp_valid", rsp_valid, 1'b1);
      chk("to_next_rsp_id", rsp_id, 1'b1);
      chk("to_next_rsp_err", rsp_err, 1'b0);
      chk("to_next_rsp_rdata", rsp_rdata, 32'h55);
      pready = 1'b0;
`endif

      // Reset during ACCESS with two commands queued
      @(negedge clk);
      req_valid = 2'b11; req_rnw = 2'b11; pready = 1'b0;
      repeat (3) @(negedge clk);
      req_valid = 2'b00;
      chk("rs_psel_access", psel, 1'b1);
      chk("rs_penable_access", penable, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("rs_psel", psel, 1'b0);
      chk("rs_penable", penable, 1'b0);
      chk("rs_rsp_valid", rsp_valid, 1'b0);
      reset = 1'b0; pready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rs_post_rsp_valid", rsp_valid, 1'b0);
         chk("rs_post_psel", psel, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
